// File: rtl/pc_adder.sv
// Next-PC generation for the fetch stage: sequential, branch and register-relative
// jump targets, a 4:1 next-PC select and the architectural PC register.
module pc_adder #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_in,
  output logic [31:0] pc_next,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  input  logic [1:0]  pc_sel,
  input  logic        stall,
  output logic [31:0] branch_target,
  output logic [31:0] jalr_target,
  output logic [31:0] pc_d,
  output logic [31:0] pc_q,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JALR   = 2'd2,
    SEL_TRAP   = 2'd3
  } sel_e;

  sel_e        sel;
  logic [31:0] jalr_sum;

  assign sel = sel_e'(pc_sel);

  // All sums are 32 bits wide so the carry out is dropped and wrap is silent.
  always_comb begin
    pc_next       = pc_in + 32'd4;
    branch_target = pc_in + imm;
    jalr_sum      = rs1 + imm;
    jalr_target   = {jalr_sum[31:1], 1'b0};
  end

  always_comb begin
    pc_d = pc_next;
    unique case (sel)
      SEL_SEQ:    pc_d = pc_next;
      SEL_BRANCH: pc_d = branch_target;
      SEL_JALR:   pc_d = jalr_target;
      SEL_TRAP:   pc_d = TRAP_VEC;
      default:    pc_d = pc_next;
    endcase
  end

  // Advisory only; the register still loads a misaligned pc_d.
  assign misaligned = |pc_d[1:0];

  always_ff @(posedge clk) begin
    if (!rst_n)
      pc_q <= RESET_PC;
    else if (!stall)
      pc_q <= pc_d;
  end

endmodule

// File: tb/tb_pc_adder.sv
// Randomized and directed checks of pc_adder against a behavioural next-PC model.
module tb_pc_adder;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP   = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_in, pc_drv;
  logic        tie;
  logic [31:0] pc_next, imm, rs1, branch_target, jalr_target, pc_d, pc_q;
  logic [1:0]  pc_sel;
  logic        stall, misaligned;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [31:0] model_pc;

  assign pc_in = tie ? pc_q : pc_drv;

  pc_adder #(.RESET_PC(RST_PC), .TRAP_VEC(TRAP)) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .pc_next(pc_next), .imm(imm),
    .rs1(rs1), .pc_sel(pc_sel), .stall(stall), .branch_target(branch_target),
    .jalr_target(jalr_target), .pc_d(pc_d), .pc_q(pc_q), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] i,
                                           input logic [31:0] r, input logic [1:0] s);
    logic [63:0] wide;
    case (s)
      2'd0: wide = {32'd0, pc} + 64'd4;
      2'd1: wide = {32'd0, pc} + {32'd0, i};
      2'd2: wide = ({32'd0, r} + {32'd0, i}) & 64'h0000_0000_FFFF_FFFE;
      default: wide = {32'd0, TRAP};
    endcase
    return wide[31:0];
  endfunction

  task automatic check_comb(input string name);
    logic [31:0] e_next, e_br, e_jr, e_d;
    logic        e_mis;
    e_next = (pc_in + 33'd4) % 33'h1_0000_0000;
    e_br   = ref_next(pc_in, imm, rs1, 2'd1);
    e_jr   = ref_next(pc_in, imm, rs1, 2'd2);
    e_d    = ref_next(pc_in, imm, rs1, pc_sel);
    e_mis  = (e_d % 4) != 0;
    vectors += 5;
    if (pc_next !== e_next) begin miscompares++; $display("FAIL %s pc_next got %h want %h", name, pc_next, e_next); end
    if (branch_target !== e_br) begin miscompares++; $display("FAIL %s branch_target got %h want %h", name, branch_target, e_br); end
    if (jalr_target !== e_jr) begin miscompares++; $display("FAIL %s jalr_target got %h want %h", name, jalr_target, e_jr); end
    if (pc_d !== e_d) begin miscompares++; $display("FAIL %s pc_d got %h want %h", name, pc_d, e_d); end
    if (misaligned !== e_mis) begin miscompares++; $display("FAIL %s misaligned got %b want %b", name, misaligned, e_mis); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tie = 1'b0; pc_drv = 32'h1234_5678; rst_n = 1'b0; stall = 1'b0; pc_sel = 2'd0;
    imm = '0; rs1 = '0;
    @(negedge clk);
    model_pc = RST_PC;
    vectors++;
    if (pc_q !== RST_PC) begin miscompares++; $display("FAIL reset pc_q got %h want %h", pc_q, RST_PC); end
    check_comb("reset_comb");
  endtask

  task automatic test_increment();
    logic [31:0] pcs [4] = '{32'h0, 32'h4, 32'h1000_0000, 32'hFFFF_FFFC};
    logic [31:0] want [4] = '{32'h4, 32'h8, 32'h1000_0004, 32'h0};
    tie = 1'b0; pc_sel = 2'd0; imm = 32'h4; rs1 = 32'h10;
    for (int unsigned k = 0; k < 4; k++) begin
      pc_drv = pcs[k];
      #1;
      vectors++;
      if (pc_next !== want[k]) begin miscompares++; $display("FAIL incr pc_next got %h want %h", pc_next, want[k]); end
      check_comb("incr");
    end
    vectors++;
    if (branch_target !== 32'h0) begin miscompares++; $display("FAIL wrap branch_target got %h want 0", branch_target); end
  endtask

  task automatic test_branch_jalr();
    tie = 1'b0; pc_drv = 32'h100; imm = 32'hFFFF_FFF8; rs1 = 32'h2003; pc_sel = 2'd2;
    #1;
    vectors += 3;
    if (branch_target !== 32'hF8) begin miscompares++; $display("FAIL br branch_target got %h want f8", branch_target); end
    if (jalr_target !== 32'h1FFA) begin miscompares++; $display("FAIL jalr jalr_target got %h want 1ffa", jalr_target); end
    if (misaligned !== 1'b1) begin miscompares++; $display("FAIL jalr misaligned got %b want 1", misaligned); end
    pc_drv = 32'h10; imm = 32'hFFFF_FFF0; pc_sel = 2'd1;
    #1;
    vectors++;
    if (branch_target !== 32'h0) begin miscompares++; $display("FAIL back branch_target got %h want 0", branch_target); end
    check_comb("back");
  endtask

  task automatic test_random_comb();
    tie = 1'b0;
    for (int unsigned k = 0; k < 40; k++) begin
      pc_drv = $urandom; imm = $urandom; rs1 = $urandom; pc_sel = 2'($urandom_range(0, 3));
      #1;
      check_comb("rand_comb");
    end
  endtask

  task automatic test_register_path();
    logic [31:0] want [3] = '{32'h4, 32'h8, 32'hC};
    test_reset();
    rst_n = 1'b1; tie = 1'b1; pc_sel = 2'd0; stall = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if (pc_q !== want[k]) begin miscompares++; $display("FAIL seq pc_q got %h want %h", pc_q, want[k]); end
    end
    model_pc = 32'hC;
  endtask

  task automatic test_stall_trap();
    stall = 1'b1; pc_sel = 2'd1; imm = 32'h40;
    for (int unsigned k = 0; k < 2; k++) begin
      @(negedge clk);
      vectors++;
      if (pc_q !== model_pc) begin miscompares++; $display("FAIL stall pc_q got %h want %h", pc_q, model_pc); end
    end
    stall = 1'b0; pc_sel = 2'd3;
    @(negedge clk);
    model_pc = TRAP;
    vectors++;
    if (pc_q !== 32'h100) begin miscompares++; $display("FAIL trap pc_q got %h want 100", pc_q); end
  endtask

  task automatic test_reset_priority();
    rst_n = 1'b0; stall = 1'b1; pc_sel = 2'd1;
    #1;
    vectors++;
    if (pc_q !== model_pc) begin miscompares++; $display("FAIL rst_before_edge pc_q got %h want %h", pc_q, model_pc); end
    @(negedge clk);
    model_pc = RST_PC;
    vectors++;
    if (pc_q !== RST_PC) begin miscompares++; $display("FAIL rst_prio pc_q got %h want %h", pc_q, RST_PC); end
    rst_n = 1'b1; stall = 1'b0; pc_sel = 2'd0;
    @(negedge clk);
    model_pc = RST_PC + 32'd4;
    vectors++;
    if (pc_q !== model_pc) begin miscompares++; $display("FAIL post_rst pc_q got %h want %h", pc_q, model_pc); end
  endtask

  task automatic test_random_seq();
    tie = 1'b1;
    for (int unsigned k = 0; k < 200; k++) begin
      rst_n  = ($urandom_range(0, 9) != 0);
      stall  = ($urandom_range(0, 3) == 0);
      pc_sel = 2'($urandom_range(0, 3));
      imm    = $urandom;
      rs1    = $urandom;
      #1;
      check_comb("seq_comb");
      if (!rst_n) model_pc = RST_PC;
      else if (!stall) model_pc = ref_next(model_pc, imm, rs1, pc_sel);
      @(negedge clk);
      vectors++;
      if (pc_q !== model_pc) begin miscompares++; $display("FAIL rand_seq pc_q got %h want %h", pc_q, model_pc); end
    end
  endtask

  initial begin
    tie = 1'b0; pc_drv = '0; imm = '0; rs1 = '0; pc_sel = '0; stall = 1'b0; rst_n = 1'b0;
    test_reset();
    test_increment();
    test_branch_jalr();
    test_random_comb();
    test_register_path();
    test_stall_trap();
    test_reset_priority();
    test_random_seq();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
